// File: rtl/frame_ser_pkg.sv
// rtl/frame_ser_pkg.sv - shared types and helpers for the frame serializer
package frame_ser_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        DATA,
        PAR
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hA5;

    // Clock cycles from the first sync bit through the last bit of a frame.
    function automatic int frame_len(input int sync_w, input int data_w,
                                     input int parity_en, input int div);
        return (sync_w + data_w + parity_en) * div;
    endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// rtl/bit_tick_gen.sv - bit-period tick generator, one tick every DIV cycles while running
module bit_tick_gen #(
    parameter int DIV = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    // Held at zero while idle so the first bit of a frame always gets a full period.
    always_ff @(posedge clk) begin
        if (!rst_n || !run || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = run && (cnt == CW'(DIV - 1));

endmodule

// File: rtl/frame_serializer.sv
// rtl/frame_serializer.sv - word-to-serial framer: sync word, payload, optional even parity
import frame_ser_pkg::*;

module frame_serializer #(
    parameter int               DATA_W    = 32,
    parameter int               DIV       = 8,
    parameter int               SYNC_W    = 8,
    parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(DEFAULT_SYNC_WORD),
    parameter bit               MSB_FIRST = 1'b1,
    parameter bit               PARITY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_en,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              data_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int FRAME_W = SYNC_W + DATA_W + (PARITY_EN ? 1 : 0);
    localparam int MAX_W   = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int CNT_W   = $clog2(MAX_W + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bit_q, bit_d;
    logic [FRAME_W-1:0] sh_q, sh_d;
    logic               dout_q, dout_d;
    logic               done_c;
    logic               tick;
    logic               accept;
    logic [DATA_W-1:0]  payload_ord;
    logic [FRAME_W-1:0] load_vec;

    assign in_ready   = (state_q == IDLE) && tx_en && rst_n;
    assign accept     = in_valid && in_ready;
    assign busy       = (state_q != IDLE);
    assign data_out   = dout_q;
    assign frame_done = done_c && rst_n;

    bit_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (busy),
        .tick  (tick)
    );

    // Payload is reordered at load time so the whole frame always shifts out MSB first.
    always_comb begin
        payload_ord = '0;
        for (int i = 0; i < DATA_W; i++) begin
            payload_ord[DATA_W-1-i] = MSB_FIRST ? in_data[DATA_W-1-i] : in_data[i];
        end
    end

    generate
        if (PARITY_EN) begin : g_par
            assign load_vec = {SYNC_WORD, payload_ord, ^in_data};
        end else begin : g_nopar
            assign load_vec = {SYNC_WORD, payload_ord};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        dout_d  = dout_q;
        done_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SYNC;
                    bit_d   = '0;
                    dout_d  = load_vec[FRAME_W-1];
                    sh_d    = load_vec << 1;
                end
            end
            SYNC: begin
                if (tick) begin
                    dout_d = sh_q[FRAME_W-1];
                    sh_d   = sh_q << 1;
                    if (bit_q == CNT_W'(SYNC_W - 1)) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_q == CNT_W'(DATA_W - 1)) begin
                        bit_d = '0;
                        if (PARITY_EN) begin
                            state_d = PAR;
                            dout_d  = sh_q[FRAME_W-1];
                            sh_d    = sh_q << 1;
                        end else begin
                            state_d = IDLE;
                            dout_d  = 1'b0;
                            done_c  = 1'b1;
                        end
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        dout_d = sh_q[FRAME_W-1];
                        sh_d   = sh_q << 1;
                    end
                end
            end
            PAR: begin
                if (tick) begin
                    state_d = IDLE;
                    dout_d  = 1'b0;
                    done_c  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                dout_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bit_q   <= '0;
            sh_q    <= '0;
            dout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            dout_q  <= dout_d;
        end
    end

endmodule

// File: tb/tb_frame_serializer.sv
// tb/tb_frame_serializer.sv - scoreboard bench for frame_serializer across three parameter sets
module tb_frame_serializer;

    typedef struct packed {
        logic d;
        logic busy;
        logic done;
        logic rdy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_en;
    logic        in_valid;
    logic [31:0] in_data;

    logic r0, d0, b0, f0;
    logic r1, d1, b1, f1;
    logic r2, d2, b2, f2;
    logic o_r, o_d, o_b, o_f;

    int   sel;
    int   cfg_dw, cfg_div, cfg_msb, cfg_par;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    frame_serializer u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_en      (tx_en),
        .in_valid   (in_valid && sel == 0),
        .in_data    (in_data),
        .in_ready   (r0),
        .data_out   (d0),
        .busy       (b0),
        .frame_done (f0)
    );

    frame_serializer #(
        .DATA_W    (8),
        .DIV       (1),
        .MSB_FIRST (1'b0),
        .PARITY_EN (1'b0)
    ) u_lsb (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_en      (tx_en),
        .in_valid   (in_valid && sel == 1),
        .in_data    (in_data[7:0]),
        .in_ready   (r1),
        .data_out   (d1),
        .busy       (b1),
        .frame_done (f1)
    );

    frame_serializer #(
        .DATA_W (8),
        .DIV    (2)
    ) u_b2b (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_en      (tx_en),
        .in_valid   (in_valid && sel == 2),
        .in_data    (in_data[7:0]),
        .in_ready   (r2),
        .data_out   (d2),
        .busy       (b2),
        .frame_done (f2)
    );

    always_comb begin
        case (sel)
            0:       begin o_r = r0; o_d = d0; o_b = b0; o_f = f0; end
            1:       begin o_r = r1; o_d = d1; o_b = b1; o_f = f1; end
            default: begin o_r = r2; o_d = d2; o_b = b2; o_f = f2; end
        endcase
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic select(input int s);
        sel = s;
        case (s)
            0:       begin cfg_dw = 32; cfg_div = 8; cfg_msb = 1; cfg_par = 1; end
            1:       begin cfg_dw = 8;  cfg_div = 1; cfg_msb = 0; cfg_par = 0; end
            default: begin cfg_dw = 8;  cfg_div = 2; cfg_msb = 1; cfg_par = 1; end
        endcase
    endtask

    // Expected line, one entry per clock cycle, built from the frame definition.
    task automatic push_frame(input logic [31:0] w);
        logic [7:0] sw;
        logic       b;
        int         nb;
        sw = 8'hA5;
        nb = 8 + cfg_dw + cfg_par;
        for (int i = 0; i < nb; i++) begin
            if (i < 8) begin
                b = sw[7-i];
            end else if (i < 8 + cfg_dw) begin
                b = (cfg_msb != 0) ? w[cfg_dw-1-(i-8)] : w[i-8];
            end else begin
                b = 1'b0;
                for (int j = 0; j < cfg_dw; j++) b = b ^ w[j];
            end
            for (int j = 0; j < cfg_div; j++) begin
                sbq.push_back('{d: b, busy: 1'b1,
                                done: (i == nb - 1) && (j == cfg_div - 1), rdy: 1'b0});
            end
        end
    endtask

    task automatic push_idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) sbq.push_back('{d: 1'b0, busy: 1'b0, done: 1'b0, rdy: rdy});
    endtask

    task automatic drain_n(input int n, input bit toggle);
        exp_t e;
        for (int i = 0; i < n && sbq.size() > 0; i++) begin
            e = sbq.pop_front();
            chk($sformatf("data_out[s%0d c%0d]", sel, i), o_d, e.d);
            chk($sformatf("busy[s%0d c%0d]", sel, i), o_b, e.busy);
            chk($sformatf("frame_done[s%0d c%0d]", sel, i), o_f, e.done);
            chk($sformatf("in_ready[s%0d c%0d]", sel, i), o_r, e.rdy);
            if (toggle) in_data = ~in_data;
            @(negedge clk);
        end
    endtask

    task automatic send(input logic [31:0] w, input bit toggle);
        chk("in_ready_before_accept", o_r, 1'b1);
        in_valid = 1'b1;
        in_data  = w;
        push_frame(w);
        push_idle(1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        drain_n(sbq.size(), toggle);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout waiting for bench to complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        tx_en    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        select(0);
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            select(s);
            #1;
            chk("reset_data_out", o_d, 1'b0);
            chk("reset_busy", o_b, 1'b0);
            chk("reset_frame_done", o_f, 1'b0);
            chk("reset_in_ready", o_r, 1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Default parameters: 328-cycle frame, parity 1.
        select(0);
        send(32'h1234_5678, 1'b0);

        // Payload latched at accept while in_data churns.
        send(32'hDEAD_BEEF, 1'b1);

        // LSB-first, no parity, one bit per clock.
        select(1);
        send(32'h0000_0001, 1'b0);
        send(32'h0000_00C3, 1'b0);

        // Back-to-back with in_valid held: one idle cycle between frames.
        select(2);
        chk("b2b_ready_before_first", o_r, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'h0000_00FF;
        push_frame(32'h0000_00FF);
        push_idle(1, 1'b1);
        @(negedge clk);
        in_data = 32'h0000_0000;
        drain_n(sbq.size(), 1'b0);
        in_valid = 1'b0;
        push_frame(32'h0000_0000);
        push_idle(2, 1'b1);
        drain_n(sbq.size(), 1'b0);

        // Reset during the DATA field aborts the frame.
        select(0);
        chk("rst_ready_before_accept", o_r, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'hCAFE_F00D;
        push_frame(32'hCAFE_F00D);
        @(negedge clk);
        in_valid = 1'b0;
        drain_n(100, 1'b0);
        sbq.delete();
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_data_out", o_d, 1'b0);
        chk("midrst_busy", o_b, 1'b0);
        chk("midrst_frame_done", o_f, 1'b0);
        chk("midrst_in_ready", o_r, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("midrst_ready_after_release", o_r, 1'b1);
        push_idle(3, 1'b1);
        drain_n(sbq.size(), 1'b0);
        send(32'h8000_0001, 1'b0);

        // tx_en dropped during SYNC: frame completes, acceptance blocked until re-enabled.
        chk("txen_ready_before_accept", o_r, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'h0F0F_0F0F;
        push_frame(32'h0F0F_0F0F);
        @(negedge clk);
        in_valid = 1'b0;
        drain_n(10, 1'b0);
        tx_en    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'hA5A5_0001;
        drain_n(sbq.size(), 1'b0);
        push_idle(4, 1'b0);
        drain_n(sbq.size(), 1'b0);
        tx_en = 1'b1;
        #1;
        chk("txen_ready_on_raise", o_r, 1'b1);
        push_frame(32'hA5A5_0001);
        push_idle(1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        drain_n(sbq.size(), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
